// File: rtl/branch_compare.sv
// Multi-cycle branch comparator: walks the latched operands one nibble per
// cycle from the MSB down and reports more/even/less with early exit.
module branch_compare (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct_3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        busy,
  output logic        done,
  output logic        more,
  output logic        even,
  output logic        less
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_uns;
  logic [2:0]  r_idx;
  logic        r_busy;
  logic        r_done;
  logic        r_more;
  logic        r_even;
  logic        r_less;

  logic [3:0]  w_a_nib;
  logic [3:0]  w_b_nib;
  logic        w_sign_flip;
  logic        w_unused_f3;

  function automatic logic [3:0] nibble_at(input logic [31:0] v, input logic [2:0] i);
    nibble_at = v[{i, 2'b00} +: 4];
  endfunction

  assign w_unused_f3 = funct_3[2] ^ funct_3[0];

  // Signed compares become unsigned once both sign bits are flipped on the top nibble.
  assign w_sign_flip = (r_idx == 3'd7) && !r_uns;
  assign w_a_nib     = nibble_at(r_a, r_idx) ^ {w_sign_flip, 3'b000};
  assign w_b_nib     = nibble_at(r_b, r_idx) ^ {w_sign_flip, 3'b000};

  // Control FSM with registered status and result flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_uns   <= 1'b0;
      r_idx   <= 3'd7;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_more  <= 1'b0;
      r_even  <= 1'b0;
      r_less  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= rs1;
            r_b     <= rs2;
            r_uns   <= funct_3[1];
            r_idx   <= 3'd7;
            r_more  <= 1'b0;
            r_even  <= 1'b0;
            r_less  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_CMP;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_CMP: begin
          if (w_a_nib != w_b_nib) begin
            r_more  <= (w_a_nib > w_b_nib);
            r_less  <= (w_a_nib < w_b_nib);
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (r_idx == 3'd0) begin
            r_even  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_idx   <= r_idx - 3'd1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign more = r_more;
  assign even = r_even;
  assign less = r_less;

endmodule

// File: tb/tb_branch_compare.sv
// Directed bench for branch_compare: an abstract result/latency model is checked
// every cycle, and directed vectors pin literal latencies and flags.
module tb_branch_compare;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct_3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy, done, more, even, less;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  branch_compare dut (
    .clk(clk), .rst(rst), .start(start), .funct_3(funct_3),
    .rs1(rs1), .rs2(rs2), .busy(busy), .done(done),
    .more(more), .even(even), .less(less)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result as {more, even, less} from whole-word arithmetic.
  function automatic logic [2:0] ref_flags(input logic [31:0] a, input logic [31:0] b, input logic uns);
    if (a == b) return 3'b010;
    if (uns) return (a > b) ? 3'b100 : 3'b001;
    return ($signed(a) > $signed(b)) ? 3'b100 : 3'b001;
  endfunction

  // Cycles spent = nibbles examined until the first difference from the top.
  function automatic int ref_cycles(input logic [31:0] a, input logic [31:0] b);
    for (int n = 7; n >= 0; n--)
      if (a[n*4 +: 4] != b[n*4 +: 4]) return 8 - n;
    return 8;
  endfunction

  int         m_rem;
  logic       m_done;
  logic [2:0] m_flags;
  logic [2:0] m_res;

  // Model: a busy countdown and the pending result, reset asynchronously.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem   <= 0;
      m_done  <= 1'b0;
      m_flags <= 3'b000;
      m_res   <= 3'b000;
    end else if (m_rem != 0) begin
      m_rem  <= m_rem - 1;
      m_done <= (m_rem == 1);
      if (m_rem == 1) m_flags <= m_res;
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_res   <= ref_flags(rs1, rs2, funct_3[1]);
        m_rem   <= ref_cycles(rs1, rs2);
        m_flags <= 3'b000;
      end
    end
  end

  // Compare process on the inactive edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", {31'd0, busy}, {31'd0, (m_rem != 0)});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("flags", {29'd0, more, even, less}, {29'd0, m_flags});
    end
  end

  task automatic wait_done(input string name, output int cyc);
    int guard;
    cyc = 0;
    guard = 0;
    while (!done && guard < 40) begin
      if (busy) cyc++;
      @(negedge clk);
      guard++;
    end
    chk({name, "_done"}, {31'd0, done}, 32'd1);
    chk({name, "_onehot"}, $countones({more, even, less}), 32'd1);
  endtask

  task automatic run_cmp(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f3, input int ek, input logic [2:0] ef);
    int cyc;
    rs1 = a; rs2 = b; funct_3 = f3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(name, cyc);
    chk({name, "_cycles"}, cyc, ek);
    chk({name, "_flags"}, {29'd0, more, even, less}, {29'd0, ef});
  endtask

  task automatic run_model_only(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3);
    int cyc;
    rs1 = a; rs2 = b; funct_3 = f3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rs1 = $urandom; rs2 = $urandom;
    wait_done("rand", cyc);
  endtask

  initial begin
    int cyc;
    logic [31:0] ra;
    rst = 1'b1; start = 1'b0; funct_3 = 3'b000; rs1 = 32'd0; rs2 = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {27'd0, busy, done, more, even, less}, 32'd0);
    rst = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);

    run_cmp("req029", 32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 1, 3'b001);
    run_cmp("req030", 32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 1, 3'b100);
    run_cmp("req031", 32'h1234_5678, 32'h1234_5678, 3'b000, 8, 3'b010);
    run_cmp("req032", 32'h0000_0010, 32'h0000_0011, 3'b101, 8, 3'b001);
    run_cmp("sgn_min", 32'h8000_0000, 32'h7FFF_FFFF, 3'b100, 1, 3'b001);
    run_cmp("uns_min", 32'h8000_0000, 32'h7FFF_FFFF, 3'b111, 1, 3'b100);
    run_cmp("mid_nib", 32'hFFFF_0000, 32'hFFFE_0000, 3'b101, 4, 3'b100);
    run_cmp("uns_low", 32'hABCD_EF00, 32'hABCD_EF01, 3'b110, 8, 3'b001);
    @(negedge clk);

    // Start while busy must be ignored, and input wiggles must not matter.
    rs1 = 32'h1234_5678; rs2 = 32'h1234_5678; funct_3 = 3'b000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rs1 = 32'd0; rs2 = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0; rs1 = 32'hDEAD_BEEF; funct_3 = 3'b111;
    wait_done("req033", cyc);
    chk("req033_cycles", cyc + 2, 32'd8);
    chk("req033_flags", {29'd0, more, even, less}, 32'd2);
    @(negedge clk);

    // Reset three cycles into an equal compare.
    rs1 = 32'h1234_5678; rs2 = 32'h1234_5678; funct_3 = 3'b000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("req034_async", {27'd0, busy, done, more, even, less}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("req034_no_done", {31'd0, done}, 32'd0);
    end
    run_cmp("req034", 32'h0000_0007, 32'h0000_0003, 3'b100, 8, 3'b100);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      case (i % 4)
        0: run_model_only(ra, $urandom, 3'b100);
        1: run_model_only(ra, ra ^ (32'd1 << $urandom_range(31, 0)), 3'b110);
        2: run_model_only(ra, ra, 3'b001);
        default: run_model_only(ra, ~ra, 3'b111);
      endcase
    end
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
